// File: rtl/video_timing_pkg.sv
// Shared constants, standard mode parameter sets and the timing-set legality check
// for the video timing generator.
package video_timing_pkg;

    localparam int unsigned CW_DEFAULT = 12;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } mode_t;

    localparam mode_t MODE_720P60    = '{1280, 110, 40, 220, 720, 5, 5, 20};
    localparam mode_t MODE_1080P60   = '{1920, 88, 44, 148, 1080, 4, 5, 36};
    localparam mode_t MODE_640X480P60 = '{640, 16, 96, 48, 480, 10, 2, 33};

    // A set is usable when no field is zero and neither total exceeds the counter range.
    function automatic logic timing_legal(
        input int unsigned cw,
        input logic [31:0] h_active, h_fp, h_sync, h_bp,
        input logic [31:0] v_active, v_fp, v_sync, v_bp
    );
        logic [33:0] h_total;
        logic [33:0] v_total;
        logic [33:0] limit;
        h_total = 34'(h_active) + 34'(h_fp) + 34'(h_sync) + 34'(h_bp);
        v_total = 34'(v_active) + 34'(v_fp) + 34'(v_sync) + 34'(v_bp);
        limit   = 34'd1 << cw;
        return (h_active != 0) && (h_fp != 0) && (h_sync != 0) && (h_bp != 0) &&
               (v_active != 0) && (v_fp != 0) && (v_sync != 0) && (v_bp != 0) &&
               (h_total <= limit) && (v_total <= limit);
    endfunction

endpackage

// File: rtl/vt_axis_counter.sv
// One timing axis: position counter with registered sync/active flags aligned to the count.
module vt_axis_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          count_en,
    input  logic          wrap_in,
    input  logic [CW-1:0] len_active,
    input  logic [CW-1:0] len_fp,
    input  logic [CW-1:0] len_sync,
    input  logic [CW-1:0] len_bp,
    output logic [CW-1:0] count,
    output logic          sync_flag,
    output logic          active_flag,
    output logic          wrap_out
);

    logic [CW+1:0] sync_start;
    logic [CW+1:0] sync_end;
    logic [CW+1:0] total;
    logic [CW+1:0] count_inc;
    logic          advance;

    always_comb begin
        sync_start = {2'b00, len_active} + {2'b00, len_fp};
        sync_end   = sync_start + {2'b00, len_sync};
        total      = sync_end + {2'b00, len_bp};
        count_inc  = {2'b00, count} + (CW+2)'(1);
    end

    assign advance  = count_en && wrap_in;
    assign wrap_out = advance && (count_inc == total);

    // Flags are decoded from the next count so they line up with it; position 0 of a
    // legal set is always active and never in sync, whatever set takes over at the wrap.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            count       <= '0;
            sync_flag   <= 1'b0;
            active_flag <= 1'b1;
        end else if (advance) begin
            if (count_inc == total) begin
                count       <= '0;
                sync_flag   <= 1'b0;
                active_flag <= 1'b1;
            end else begin
                count       <= count_inc[CW-1:0];
                sync_flag   <= (count_inc >= sync_start) && (count_inc < sync_end);
                active_flag <= count_inc < {2'b00, len_active};
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised progressive video timing generator with pixel enable, programmable sync
// polarity and a shadowed timing set that takes effect only at frame boundaries.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CW       = CW_DEFAULT,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_load,
    output logic          cfg_pending,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] pixel_count,
    output logic [CW-1:0] line_count,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned FW = 8 * CW;
    localparam logic [FW-1:0] DEFAULT_SET = {
        CW'(H_ACTIVE), CW'(H_FP), CW'(H_SYNC), CW'(H_BP),
        CW'(V_ACTIVE), CW'(V_FP), CW'(V_SYNC), CW'(V_BP)
    };

    logic [FW-1:0] live_set;
    logic [FW-1:0] shadow_set;
    logic [FW-1:0] cfg_set;
    logic          cfg_legal;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_sync_flag;
    logic          v_sync_flag;
    logic          h_active_flag;
    logic          v_active_flag;

    assign cfg_set = {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                      cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp};

    assign cfg_legal = timing_legal(CW,
        32'(cfg_h_active), 32'(cfg_h_fp), 32'(cfg_h_sync), 32'(cfg_h_bp),
        32'(cfg_v_active), 32'(cfg_v_fp), 32'(cfg_v_sync), 32'(cfg_v_bp));

    vt_axis_counter #(.CW(CW)) u_h_axis (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .count_en    (ce),
        .wrap_in     (1'b1),
        .len_active  (live_set[8*CW-1 -: CW]),
        .len_fp      (live_set[7*CW-1 -: CW]),
        .len_sync    (live_set[6*CW-1 -: CW]),
        .len_bp      (live_set[5*CW-1 -: CW]),
        .count       (pixel_count),
        .sync_flag   (h_sync_flag),
        .active_flag (h_active_flag),
        .wrap_out    (h_wrap)
    );

    vt_axis_counter #(.CW(CW)) u_v_axis (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .count_en    (ce),
        .wrap_in     (h_wrap),
        .len_active  (live_set[4*CW-1 -: CW]),
        .len_fp      (live_set[3*CW-1 -: CW]),
        .len_sync    (live_set[2*CW-1 -: CW]),
        .len_bp      (live_set[CW-1 -: CW]),
        .count       (line_count),
        .sync_flag   (v_sync_flag),
        .active_flag (v_active_flag),
        .wrap_out    (v_wrap)
    );

    // v_wrap already implies ce and the horizontal wrap, i.e. the frame boundary.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            live_set    <= DEFAULT_SET;
            shadow_set  <= '0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            cfg_err     <= cfg_load && !cfg_legal;
            if (v_wrap) begin
                if (cfg_pending) begin
                    live_set <= shadow_set;
                end
                cfg_pending <= 1'b0;
            end
            // A load on the boundary cycle is kept for the next frame, so it wins over the clear.
            if (cfg_load && cfg_legal) begin
                shadow_set  <= cfg_set;
                cfg_pending <= 1'b1;
            end
        end
    end

    assign hsync  = HS_POL ? h_sync_flag : !h_sync_flag;
    assign vsync  = VS_POL ? v_sync_flag : !v_sync_flag;
    assign active = h_active_flag && v_active_flag;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised, single-clock video timing generator: successor of the fixed 1280x720@60 sync generator. Produces hsync, vsync, active, pixel/line counters and line/frame strobes for any CEA/VESA-style progressive mode. It adds programmable sync polarity, a pixel clock-enable, and a runtime timing-reload path applied only at frame boundaries. It sits between the pixel clock source and the framebuffer read/encoder path of the thin-client video output.

## Interface
Parameters:
- CW, 12, counter/config field width
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, visible lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level

Ports:
- pixel_clock  in  1  the only clock
- reset  in  1  synchronous, active-high
- ce  in  1  pixel enable; counters advance only when 1
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  new horizontal timing
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  new vertical timing
- cfg_load  in  1  one-cycle strobe: capture cfg_* into the shadow set
- cfg_pending  out  1  shadow set waiting for frame boundary
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- hsync, vsync  out  1  sync outputs, polarity per HS_POL/VS_POL
- active  out  1  pixel is in the visible region
- pixel_count, line_count  out  CW  current position
- line_start  out  1  first pixel of any line
- frame_start  out  1  pixel (0,0)

## Operation
- Live timing set L and shadow set S. Reset loads the parameter values into L, clears S and cfg_pending.
- H_TOTAL = h_active+h_fp+h_sync+h_bp, V_TOTAL likewise, computed in CW+2 bits. A set is legal iff every field ≥1 and both totals ≤ 2^CW.
- cfg_load with a legal set: S := cfg_*, cfg_pending := 1. A second load before apply overwrites S.
- cfg_load with an illegal set: cfg_err pulses the next cycle; S and cfg_pending unchanged.
- Apply: on the ce cycle where pixel_count wraps H_TOTAL-1→0 and line_count wraps V_TOTAL-1→0, L := S if cfg_pending was 1 before that cycle, and cfg_pending := 0. The new frame starts at (0,0) with the new timing.
- A cfg_load in the same cycle as the wrap is only captured; it applies at the following frame boundary.
- Region decode is on the presented position (h, v):
  - active = h < h_active && v < v_active.
  - hsync asserted iff h_active+h_fp ≤ h < h_active+h_fp+h_sync.
  - vsync asserted iff v_active+v_fp ≤ v < v_active+v_fp+v_sync. vsync changes only when h = 0.
- Deasserted level is !HS_POL / !VS_POL.
- Vertical counter advances only on the horizontal wrap. Everything runs in the pixel_clock domain; no derived clocks.

## Timing
- All outputs are registered and mutually aligned: hsync, vsync, active and the strobes describe exactly the pixel_count/line_count value presented in the same cycle.
- Reset values:
  - pixel_count = 0, line_count = 0, active = 1
  - hsync = !HS_POL, vsync = !VS_POL
  - line_start = 1, frame_start = 1
  - cfg_pending = 0, cfg_err = 0
- ce = 0: all position outputs hold. line_start and frame_start drop to 0 after their first presentation cycle, so each strobe is high for exactly one pixel_clock cycle per event.
- ce = 1: position advances by one pixel per cycle; latency from ce to updated outputs is one cycle.
- Reset mid-frame or mid-pending: returns to (0,0) with parameter timing the next cycle and discards S.

## Structure
- Package video_timing_pkg holds:
  - mode constants (720p60, 1080p60, 640x480@60) as parameter sets
  - the legality-check function
  - default CW
- Sub-module vt_axis_counter is instantiated twice (horizontal and vertical). It takes length fields, count enable and wrap input, and returns count, sync flag, active flag and wrap output.

## Test plan
- Reset, defaults, ce = 1 for 2 frames: H period 1650 cycles, hsync high at h = 1390..1429, vsync high on lines 725..729, frame period 1,237,500 cycles, frame_start once per frame.
- HS_POL = 0, VS_POL = 0: sync levels inverted; counters and active identical to the default run.
- ce toggled 1/0 every cycle: frame takes 2,475,000 cycles; each line_start is exactly 1 cycle wide.
- cfg_load of 640/16/96/48, 480/10/2/33 mid-frame: cfg_pending = 1 until the 720p wrap. The next frame has an 800-pixel line and 525 lines; hsync at h = 656..751.
- cfg_load with cfg_h_sync = 0, and separately with H_TOTAL = 4097 at CW = 12: cfg_err pulses; timing and cfg_pending unchanged.
- cfg_load coincident with the frame wrap, plus reset asserted while pending: the first case applies one frame later; reset returns to 720p defaults with cfg_pending = 0.
